// File: rtl/pcie_pll_rst_seq.sv
// PCIe PLL reset/lock sequencer: pulses the PLL reset, waits for a
// stable synchronized lock, then releases the downstream reset.
module pcie_pll_rst_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY           = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       sw_restart,
  output logic       pll_rst,
  output logic       dn_rst,
  output logic       ready,
  output logic       lock_sync,
  output logic [2:0] retry_cnt,
  output logic       lock_fail,
  output logic [7:0] lost_cnt
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                         PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P = (MAX_A > LOCK_TIMEOUT_CYCLES) ?
                         MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  // The lock-detect cycle in WAIT_LOCK is the first cycle of the window.
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 2);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_retry;
  logic [7:0]    r_lost;
  logic          r_pll_rst;
  logic          r_dn_rst;
  logic          r_ready;
  logic          r_lock_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_PLL_RST;
      r_cnt       <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_retry     <= 3'd0;
      r_lost      <= 8'd0;
      r_pll_rst   <= 1'b1;
      r_dn_rst    <= 1'b1;
      r_ready     <= 1'b0;
      r_lock_fail <= 1'b0;
    end else begin
      r_sync1     <= pll_lock;
      r_sync2     <= r_sync1;
      r_pll_rst   <= (r_state == S_PLL_RST) || (r_state == S_FAIL);
      r_dn_rst    <= (r_state != S_RUN);
      r_ready     <= (r_state == S_RUN);
      r_lock_fail <= (r_state == S_FAIL);

      if (sw_restart) begin
        r_state <= S_PLL_RST;
        r_cnt   <= '0;
        r_retry <= 3'd0;
      end else begin
        unique case (r_state)
          S_PLL_RST: begin
            if (r_cnt == RST_LAST) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_WAIT_LOCK: begin
            if (r_sync2) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == TO_LAST) begin
              r_cnt <= '0;
              if (r_retry == RETRY_MAX) begin
                r_state <= S_FAIL;
              end else begin
                r_retry <= r_retry + 3'd1;
                r_state <= S_PLL_RST;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_STABLE: begin
            if (!r_sync2) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == STB_LAST) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          S_RUN: begin
            if (!r_sync2) begin
              r_state <= S_PLL_RST;
              r_cnt   <= '0;
              r_retry <= 3'd0;
              if (r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
            end
          end
          S_FAIL: begin
            r_cnt <= '0;
          end
          default: begin
            r_state <= S_PLL_RST;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign pll_rst   = r_pll_rst;
  assign dn_rst    = r_dn_rst;
  assign ready     = r_ready;
  assign lock_sync = r_sync2;
  assign retry_cnt = r_retry;
  assign lock_fail = r_lock_fail;
  assign lost_cnt  = r_lost;

endmodule

// File: tb/tb_pcie_pll_rst_seq.sv
// Directed bench for pcie_pll_rst_seq: acquisition, glitch, loss,
// timeout/fail, software restart and reset behaviour.
module tb_pcie_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_lock;
  logic       sw_restart;
  logic       pll_rst;
  logic       dn_rst;
  logic       ready;
  logic       lock_sync;
  logic [2:0] retry_cnt;
  logic       lock_fail;
  logic [7:0] lost_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  pcie_pll_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .sw_restart (sw_restart),
    .pll_rst    (pll_rst),
    .dn_rst     (dn_rst),
    .ready      (ready),
    .lock_sync  (lock_sync),
    .retry_cnt  (retry_cnt),
    .lock_fail  (lock_fail),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Call on the first sample with pll_rst high; returns one sample after it drops.
  task automatic pulse_len(input string tag);
    int n;
    n = 0;
    while (pll_rst && n < 100) begin
      n++;
      tick();
    end
    chk(tag, n, 16);
  endtask

  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ready && k < budget) begin
      tick();
      k++;
    end
    chk("wait_ready", int'(ready), 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"},   int'(pll_rst),   1);
    chk({tag, "_dn_rst"},    int'(dn_rst),    1);
    chk({tag, "_ready"},     int'(ready),     0);
    chk({tag, "_lock_fail"}, int'(lock_fail), 0);
    chk({tag, "_retry"},     int'(retry_cnt), 0);
    chk({tag, "_lost"},      int'(lost_cnt),  0);
    chk({tag, "_sync"},      int'(lock_sync), 0);
  endtask

  initial begin
    int rises;
    int first_rise;
    int last_rise;
    int fail_at;
    logic prev;

    rst        = 1'b1;
    pll_lock   = 1'b0;
    sw_restart = 1'b0;

    // Reset state
    ticks(3);
    chk_reset_vals("rst");

    // Nominal acquisition: 16-cycle pulse, lock at +100, ready at +67
    rst = 1'b0;
    tick();
    pulse_len("init_pulse");
    chk("init_pll_rst_low", int'(pll_rst), 0);
    ticks(83);
    pll_lock = 1'b1;
    ticks(66);
    chk("acq_ready_early", int'(ready), 0);
    tick();
    chk("acq_ready", int'(ready), 1);
    chk("acq_dn_rst", int'(dn_rst), 0);
    chk("acq_retry", int'(retry_cnt), 0);
    chk("acq_sync", int'(lock_sync), 1);

    // Lock loss in RUN
    pll_lock = 1'b0;
    ticks(3);
    chk("loss_ready_hold", int'(ready), 1);
    tick();
    chk("loss_ready", int'(ready), 0);
    chk("loss_dn_rst", int'(dn_rst), 1);
    chk("loss_lost", int'(lost_cnt), 1);
    chk("loss_retry", int'(retry_cnt), 0);
    pulse_len("loss_pulse");

    // Glitch at stable count ~40 forces a fresh window
    pll_lock = 1'b1;
    ticks(40);
    chk("glitch_pre_ready", int'(ready), 0);
    pll_lock = 1'b0;
    ticks(3);
    pll_lock = 1'b1;
    ticks(66);
    chk("glitch_fresh_early", int'(ready), 0);
    tick();
    chk("glitch_ready", int'(ready), 1);
    chk("glitch_retry", int'(retry_cnt), 0);

    // sw_restart coinciding with a lock_sync drop in RUN
    pll_lock = 1'b0;
    ticks(2);
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
    chk("swdrop_lost", int'(lost_cnt), 1);
    tick();
    chk("swdrop_ready", int'(ready), 0);
    pulse_len("swdrop_pulse");

    // rst mid-STABLE
    pll_lock = 1'b1;
    ticks(20);
    chk("mid_stable_no_ready", int'(ready), 0);
    rst = 1'b1;
    tick();
    chk_reset_vals("mstb");
    pll_lock = 1'b0;
    tick();

    // Timeouts until FAIL
    rst = 1'b0;
    rises = 0;
    first_rise = 0;
    last_rise = 0;
    fail_at = 0;
    prev = pll_rst;
    for (int i = 1; i <= 40000; i++) begin
      tick();
      if (lock_fail) begin
        fail_at = i;
        break;
      end
      if (pll_rst && !prev) begin
        rises++;
        chk($sformatf("rise%0d_retry", rises), int'(retry_cnt), rises);
        if (rises == 1) first_rise = i;
        last_rise = i;
      end
      prev = pll_rst;
    end
    chk("to_rises", rises, 7);
    chk("to_first_rise", first_rise, 4113);
    chk("to_spacing", last_rise - first_rise, 6 * 4112);
    chk("to_fail_at", fail_at, 32897);
    chk("fail_pll_rst", int'(pll_rst), 1);
    chk("fail_retry", int'(retry_cnt), 7);
    ticks(100);
    chk("fail_hold", int'(lock_fail), 1);
    chk("fail_hold_pll_rst", int'(pll_rst), 1);

    // sw_restart out of FAIL
    sw_restart = 1'b1;
    tick();
    sw_restart = 1'b0;
    chk("sw_retry", int'(retry_cnt), 0);
    tick();
    chk("sw_lock_fail", int'(lock_fail), 0);
    pulse_len("sw_pulse");

    // 300 losses saturate lost_cnt
    pll_lock = 1'b1;
    for (int j = 0; j < 300; j++) begin
      wait_ready(300);
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      ticks(4);
    end
    chk("lost_sat", int'(lost_cnt), 255);
    chk("lost_sat_ready", int'(ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
